// File: rtl/matvec3_pkg.sv
// matvec3_pkg: shared widths and FSM state codes for the 3x3 matrix-vector multiplier
package matvec3_pkg;
   localparam int T = 14;
   localparam int K = 3;
   localparam int W = 2 * T;
   localparam logic [1:0] LOAD_M  = 2'd0;
   localparam logic [1:0] LOAD_X  = 2'd1;
   localparam logic [1:0] COMPUTE = 2'd2;
   localparam logic [1:0] OUTPUT  = 2'd3;
endpackage

// File: rtl/matvec3_mac.sv
// matvec3_mac: signed TxT multiply into a W-bit accumulator that wraps modulo 2^W
module matvec3_mac
   import matvec3_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                clr,
   input  logic                en,
   input  logic signed [T-1:0] a,
   input  logic signed [T-1:0] b,
   output logic signed [W-1:0] acc
);
   logic signed [W-1:0] prod;
   assign prod = W'(a) * W'(b);
   always_ff @(posedge clk)
      acc <= (reset || clr) ? '0 : en ? acc + prod : acc;
endmodule

// File: rtl/matvec3_part2.sv
// matvec3_part2: streaming y = M*x with a reusable stored matrix and valid/ready on both sides
module matvec3_part2
   import matvec3_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                input_valid,
   output logic                input_ready,
   input  logic signed [T-1:0] input_data,
   input  logic                new_matrix,
   output logic                output_valid,
   input  logic                output_ready,
   output logic signed [W-1:0] output_data
);
   logic [1:0] state, row, j;
   logic [3:0] cnt, idx;
   logic first, take, give, clr, en;
   logic signed [T-1:0] m [K*K];
   logic signed [T-1:0] x [K];
   assign input_ready  = !reset && (state == LOAD_M || state == LOAD_X);
   assign output_valid = !reset && state == OUTPUT;
   assign take = input_valid && input_ready;
   assign give = output_valid && output_ready;
   // the accumulator is cleared on the edge that enters COMPUTE for each row
   assign clr  = (take && state == LOAD_X && cnt == 4'd2) || (give && row != 2'd2);
   assign en   = state == COMPUTE;
   assign idx  = 4'(row) * 4'd3 + 4'(j);
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LOAD_M;
         cnt   <= '0;
         row   <= '0;
         j     <= '0;
         first <= 1'b1;
         for (int i = 0; i < K*K; i++) m[i] <= '0;
         for (int i = 0; i < K; i++) x[i] <= '0;
      end else begin
         case (state)
            LOAD_M: if (take) begin
               first <= 1'b0;
               if (first && !new_matrix) begin
                  x[0]  <= input_data;
                  cnt   <= 4'd1;
                  state <= LOAD_X;
               end else begin
                  m[cnt] <= input_data;
                  cnt    <= cnt == 4'd8 ? 4'd0 : cnt + 4'd1;
                  state  <= cnt == 4'd8 ? LOAD_X : LOAD_M;
               end
            end
            LOAD_X: if (take) begin
               x[cnt[1:0]] <= input_data;
               cnt   <= cnt == 4'd2 ? 4'd0 : cnt + 4'd1;
               state <= cnt == 4'd2 ? COMPUTE : LOAD_X;
               row   <= '0;
               j     <= '0;
            end
            COMPUTE: begin
               j     <= j == 2'd2 ? 2'd0 : j + 2'd1;
               state <= j == 2'd2 ? OUTPUT : COMPUTE;
            end
            default: if (give) begin
               row   <= row == 2'd2 ? 2'd0 : row + 2'd1;
               state <= row == 2'd2 ? LOAD_M : COMPUTE;
               first <= row == 2'd2;
            end
         endcase
      end
   end
   matvec3_mac u_mac (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .en    (en),
      .a     (m[idx]),
      .b     (x[j]),
      .acc   (output_data)
   );
endmodule

// File: tb/tb_matvec3_part2.sv
// tb_matvec3_part2: directed and randomized checks of matvec3_part2 against an arithmetic model
module tb_matvec3_part2;
   logic clk = 1'b0, reset = 1'b1, input_valid = 1'b0, new_matrix = 1'b0, output_ready = 1'b0;
   logic input_ready, output_valid;
   logic signed [13:0] input_data = '0;
   logic signed [27:0] output_data;
   int tests = 0, fails = 0;
   int mdl_m [9], mdl_x [3], nw_m [9], nw_x [3];
   time t_acc = 0;

   always #5 clk = ~clk;

   matvec3_part2 dut (
      .clk          (clk),
      .reset        (reset),
      .input_valid  (input_valid),
      .input_ready  (input_ready),
      .input_data   (input_data),
      .new_matrix   (new_matrix),
      .output_valid (output_valid),
      .output_ready (output_ready),
      .output_data  (output_data)
   );

   task automatic chk(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // y[i] = sum_j M[i][j]*x[j], reduced modulo 2^28 and read back as signed
   function automatic longint ref_y(input int i);
      longint s = 0;
      logic [27:0] t;
      for (int k = 0; k < 3; k++) s += longint'(mdl_m[i*3+k]) * longint'(mdl_x[k]);
      t = 28'(s);
      return longint'($signed(t));
   endfunction

   task automatic put(input int w, input logic nm, input bit rnd);
      int tries = 0;
      if (rnd) while ($urandom_range(1, 0) == 1) begin
         input_valid = 1'b0;
         input_data  = 14'($urandom);
         new_matrix  = 1'($urandom);
         @(negedge clk);
      end
      input_valid = 1'b1;
      input_data  = 14'(w);
      new_matrix  = nm;
      while (!input_ready && tries < 50) begin
         @(negedge clk);
         tries++;
      end
      if (tries >= 50) chk("input_ready_timeout", tries, 0);
      @(posedge clk);
      t_acc = $time;
      @(negedge clk);
      input_valid = 1'b0;
   endtask

   task automatic get(input longint exp, input bit rnd, input bit lat, input int row);
      int w = 0;
      bit rdy;
      chk("ready_low_compute", input_ready, 0);
      while (!output_valid && w < 60) begin
         @(negedge clk);
         w++;
      end
      if (w >= 60) chk("output_valid_timeout", w, 0);
      if (lat) chk("latency", longint'($time - t_acc), 35);
      chk("ready_low_output", input_ready, 0);
      for (int s = 0; s < 200; s++) begin
         rdy = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
         output_ready = rdy;
         chk($sformatf("y%0d", row), output_data, exp);
         chk("valid_held", output_valid, 1);
         @(posedge clk);
         t_acc = $time;
         @(negedge clk);
         if (rdy) break;
      end
      output_ready = 1'b0;
      chk("valid_drop", output_valid, 0);
      chk("ready_after_xfer", input_ready, row == 2 ? 1 : 0);
   endtask

   task automatic group(input bit nm, input bit rnd, input bit lat);
      if (nm) for (int i = 0; i < 9; i++) begin
         put(nw_m[i], i == 0 ? 1'b1 : 1'($urandom), rnd);
         mdl_m[i] = nw_m[i];
      end
      for (int i = 0; i < 3; i++) begin
         put(nw_x[i], (!nm && i == 0) ? 1'b0 : 1'($urandom), rnd);
         mdl_x[i] = nw_x[i];
      end
      for (int i = 0; i < 3; i++) get(ref_y(i), rnd, lat, i);
   endtask

   initial begin
      for (int i = 0; i < 9; i++) mdl_m[i] = 0;
      @(negedge clk);
      chk("rst_input_ready", input_ready, 0);
      chk("rst_output_valid", output_valid, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_output_data", output_data, 0);
      reset = 1'b0;
      #1 chk("ready_after_rst", input_ready, 1);
      @(negedge clk);

      nw_x = '{1, 2, 3};
      group(1'b0, 1'b0, 1'b1);

      nw_m = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
      nw_x = '{5, -7, 100};
      group(1'b1, 1'b0, 1'b1);
      chk("identity_model_y1", ref_y(1), -7);

      nw_m = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      nw_x = '{1, 1, 1};
      group(1'b1, 1'b0, 1'b1);
      nw_x = '{1, 0, -1};
      group(1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 9; i++) nw_m[i] = -8192;
      nw_x = '{-8192, -8192, -8192};
      group(1'b1, 1'b0, 1'b1);
      chk("wrap_model", ref_y(0), -67108864);

      for (int i = 0; i < 5; i++) put(i + 11, i == 0 ? 1'b1 : 1'b0, 1'b0);
      reset = 1'b1;
      #1 chk("midrst_output_valid", output_valid, 0);
      chk("midrst_input_ready", input_ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk("midrst_output_data", output_data, 0);
      reset = 1'b0;
      for (int i = 0; i < 9; i++) mdl_m[i] = 0;
      @(negedge clk);
      nw_x = '{1, 2, 3};
      group(1'b0, 1'b0, 1'b1);

      for (int g = 0; g < 300; g++) begin
         for (int i = 0; i < 9; i++) nw_m[i] = int'($urandom_range(16383, 0)) - 8192;
         for (int i = 0; i < 3; i++) nw_x[i] = int'($urandom_range(16383, 0)) - 8192;
         group(g == 0 || $urandom_range(2, 0) == 0, 1'b1, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
